jtframe_sdram_chmux: RTL and testbench

- Parametrised N-channel SDRAM bank-request multiplexer; the successor to the fixed four-bank ba0..ba3 wiring in the MiST top level.
- Arbitrates CHN game-side request ports onto one SDRAM controller bank port.
- Offers round-robin or fixed-priority arbitration, a hold input for download phases, and a transaction watchdog.
- Sits between the game instance and the SDRAM controller inside the frame.

---
 rtl/jtframe_sdram_chmux.sv | 141 ++++++++++++++
 tb/tb_jtframe_sdram_chmux.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sdram_chmux.sv
// N-channel SDRAM bank request multiplexer with round-robin or fixed
// priority arbitration, a download hold input and a transaction watchdog.
module jtframe_sdram_chmux #(
    parameter int CHN   = 4,
    parameter int AW    = 22,
    parameter int PRIO  = 0,
    parameter int TOUTW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [CHN*AW-1:0] ch_addr,
    input  logic [CHN-1:0]    ch_rd,
    input  logic [CHN-1:0]    ch_wr,
    input  logic [CHN*16-1:0] ch_din,
    input  logic [CHN*2-1:0]  ch_dsn,
    output logic [CHN-1:0]    ch_ack,
    output logic [CHN-1:0]    ch_dst,
    output logic [CHN-1:0]    ch_dok,
    output logic [CHN-1:0]    ch_rdy,
    output logic [AW-1:0]     sdr_addr,
    output logic              sdr_rd,
    output logic              sdr_wr,
    output logic [15:0]       sdr_din,
    output logic [1:0]        sdr_dsn,
    input  logic              sdr_ack,
    input  logic              sdr_dst,
    input  logic              sdr_dok,
    input  logic              sdr_rdy,
    output logic              busy,
    output logic              err
);
    localparam int IW = $clog2(CHN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]       state;
    logic [CHN-1:0]   gnt;
    logic [IW-1:0]    rr;
    logic [TOUTW-1:0] cnt;
    logic [CHN-1:0]   req;
    logic [IW-1:0]    win;
    logic             any;
    logic             tout;
    logic             in_req;

    assign req    = ch_rd | ch_wr;
    assign any    = |req;
    assign tout   = &cnt;
    assign in_req = state == REQ;
    assign busy   = state != IDLE;

    // Scan from lowest to highest priority so the last hit wins
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        if (PRIO != 0) begin
            for (int i = CHN - 1; i >= 0; i--)
                if (req[i]) win = IW'(i);
        end else begin
            for (int i = CHN; i >= 1; i--) begin
                idx = (int'(rr) + i) % CHN;
                if (req[idx]) win = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            rr       <= IW'(CHN - 1);
            cnt      <= '0;
            sdr_addr <= '0;
            sdr_din  <= '0;
            sdr_dsn  <= 2'b11;
            sdr_rd   <= 1'b0;
            sdr_wr   <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!hold && any) begin
                        state    <= REQ;
                        gnt      <= CHN'(1) << win;
                        rr       <= win;
                        cnt      <= '0;
                        sdr_addr <= ch_addr[win*AW +: AW];
                        sdr_din  <= ch_din[win*16 +: 16];
                        sdr_dsn  <= ch_dsn[win*2 +: 2];
                        sdr_wr   <= ch_wr[win];
                        sdr_rd   <= ch_rd[win] & ~ch_wr[win];
                    end
                end
                REQ: begin
                    if (sdr_ack) begin
                        sdr_rd <= 1'b0;
                        sdr_wr <= 1'b0;
                        cnt    <= '0;
                        if (sdr_rdy) begin
                            state <= IDLE;
                            gnt   <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (tout) begin
                        sdr_rd <= 1'b0;
                        sdr_wr <= 1'b0;
                        gnt    <= '0;
                        err    <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (sdr_rdy) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end else if (tout) begin
                        gnt   <= '0;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rdy only reaches a channel once its request has been acknowledged
    assign ch_ack = gnt & {CHN{sdr_ack & in_req}};
    assign ch_dst = gnt & {CHN{sdr_dst}};
    assign ch_dok = gnt & {CHN{sdr_dok}};
    assign ch_rdy = gnt & {CHN{sdr_rdy & ((state == WAIT) | (in_req & sdr_ack))}};
endmodule

// File: tb/tb_jtframe_sdram_chmux.sv
// Scoreboard bench for jtframe_sdram_chmux: a round-robin and a
// fixed-priority instance share stimulus; one is observed at a time.
module tb_jtframe_sdram_chmux;
    localparam int CHN = 4;
    localparam int AW  = 22;
    localparam logic [CHN*16-1:0] DIN0 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    typedef struct {
        int            ch;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    dsn;
        bit            wr;
        bit            coinc;
        bit            abort;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hold = 1'b0;
    logic [CHN*AW-1:0] ch_addr = '0;
    logic [CHN-1:0]    ch_rd = '0;
    logic [CHN-1:0]    ch_wr = '0;
    logic [CHN*16-1:0] ch_din = DIN0;
    logic [CHN*2-1:0]  ch_dsn = '0;
    logic sdr_ack = 1'b0, sdr_dst = 1'b0, sdr_dok = 1'b0, sdr_rdy = 1'b0;

    logic [CHN-1:0] a_ack, a_dst, a_dok, a_rdy, b_ack, b_dst, b_dok, b_rdy;
    logic [AW-1:0]  a_addr, b_addr;
    logic [15:0]    a_din, b_din;
    logic [1:0]     a_dsn, b_dsn;
    logic a_rd, a_wr, a_busy, a_err, b_rd, b_wr, b_busy, b_err;

    logic [CHN-1:0] m_ack, m_dst, m_dok, m_rdy;
    logic [AW-1:0]  m_addr;
    logic [15:0]    m_din;
    logic [1:0]     m_dsn;
    logic m_rd, m_wr, m_busy, m_err;

    bit sel_b = 1'b0;
    bit ctl_en = 1'b0;
    bit coinc = 1'b0;
    bit auto_drop = 1'b1;
    int ack_dly = 0, rdy_dly = 0;
    int acnt = 0, rcnt = 0;
    bit rpend = 1'b0;

    txn_t exp_q[$];
    txn_t cur;
    bit   cur_v = 1'b0;
    bit   prev_req = 1'b0;
    int   checks = 0, errors = 0, done_cnt = 0, ack_cnt = 0;

    jtframe_sdram_chmux #(.CHN(CHN), .AW(AW), .PRIO(0), .TOUTW(4)) u_rr (
        .clk(clk), .rst(rst), .hold(hold),
        .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr),
        .ch_din(ch_din), .ch_dsn(ch_dsn),
        .ch_ack(a_ack), .ch_dst(a_dst), .ch_dok(a_dok), .ch_rdy(a_rdy),
        .sdr_addr(a_addr), .sdr_rd(a_rd), .sdr_wr(a_wr),
        .sdr_din(a_din), .sdr_dsn(a_dsn),
        .sdr_ack(sdr_ack), .sdr_dst(sdr_dst), .sdr_dok(sdr_dok), .sdr_rdy(sdr_rdy),
        .busy(a_busy), .err(a_err)
    );

    jtframe_sdram_chmux #(.CHN(CHN), .AW(AW), .PRIO(1), .TOUTW(4)) u_fp (
        .clk(clk), .rst(rst), .hold(hold),
        .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr),
        .ch_din(ch_din), .ch_dsn(ch_dsn),
        .ch_ack(b_ack), .ch_dst(b_dst), .ch_dok(b_dok), .ch_rdy(b_rdy),
        .sdr_addr(b_addr), .sdr_rd(b_rd), .sdr_wr(b_wr),
        .sdr_din(b_din), .sdr_dsn(b_dsn),
        .sdr_ack(sdr_ack), .sdr_dst(sdr_dst), .sdr_dok(sdr_dok), .sdr_rdy(sdr_rdy),
        .busy(b_busy), .err(b_err)
    );

    assign m_ack  = sel_b ? b_ack  : a_ack;
    assign m_dst  = sel_b ? b_dst  : a_dst;
    assign m_dok  = sel_b ? b_dok  : a_dok;
    assign m_rdy  = sel_b ? b_rdy  : a_rdy;
    assign m_addr = sel_b ? b_addr : a_addr;
    assign m_din  = sel_b ? b_din  : a_din;
    assign m_dsn  = sel_b ? b_dsn  : a_dsn;
    assign m_rd   = sel_b ? b_rd   : a_rd;
    assign m_wr   = sel_b ? b_wr   : a_wr;
    assign m_busy = sel_b ? b_busy : a_busy;
    assign m_err  = sel_b ? b_err  : a_err;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none", nm);
    endtask

    task automatic expect_txn(input int ch, input logic [AW-1:0] a, input logic [15:0] d,
                              input logic [1:0] s, input bit w, input bit c, input bit ab);
        txn_t t;
        t.ch = ch; t.addr = a; t.din = d; t.dsn = s;
        t.wr = w; t.coinc = c; t.abort = ab;
        exp_q.push_back(t);
    endtask

    task automatic set_addr(input int k, input logic [AW-1:0] a);
        ch_addr[k*AW +: AW] = a;
    endtask

    task automatic wait_done(input int n, input int lim, input string nm);
        int k;
        k = 0;
        while (done_cnt < n && k < lim) begin
            @(negedge clk); #2;
            k++;
        end
        chk(nm, 32'(done_cnt >= n), 1);
    endtask

    task automatic settle();
        @(posedge clk); #2;
        ctl_en = 1'b0;
        sdr_ack = 1'b0; sdr_rdy = 1'b0; sdr_dst = 1'b0; sdr_dok = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        ch_rd = '0; ch_wr = '0; hold = 1'b0;
        ch_din = DIN0; ch_dsn = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    // Controller model: ack after ack_dly cycles, then dst and rdy
    initial forever begin
        @(posedge clk); #1;
        if (ctl_en) begin
            sdr_ack = 1'b0; sdr_rdy = 1'b0; sdr_dst = 1'b0; sdr_dok = 1'b0;
        end
        if (rst) begin
            acnt = 0;
            rpend = 1'b0;
        end else if (ctl_en) begin
            if (rpend) begin
                if (rcnt == 0) begin
                    sdr_rdy = 1'b1; sdr_dok = 1'b1; rpend = 1'b0;
                end else begin
                    if (rcnt == 1) sdr_dst = 1'b1;
                    rcnt--;
                end
            end else if (m_rd || m_wr) begin
                if (acnt >= ack_dly) begin
                    sdr_ack = 1'b1;
                    acnt = 0;
                    if (coinc) sdr_rdy = 1'b1;
                    else begin rpend = 1'b1; rcnt = rdy_dly; end
                end else begin
                    acnt++;
                end
            end
        end
    end

    // Monitor: pops expectations as the DUT presents requests and pulses
    initial forever begin
        logic [CHN-1:0] oh;
        @(negedge clk);
        if (rst) begin
            cur_v = 1'b0;
            prev_req = 1'b0;
        end else begin
            if ((m_rd || m_wr) && !prev_req) begin
                if (exp_q.size() == 0) fail("unexpected_grant");
                else begin
                    cur = exp_q.pop_front();
                    cur_v = 1'b1;
                    chk("sdr_addr", 32'(m_addr), 32'(cur.addr));
                    chk("sdr_din", 32'(m_din), 32'(cur.din));
                    chk("sdr_dsn", 32'(m_dsn), 32'(cur.dsn));
                    chk("sdr_wr_rd", {30'd0, m_wr, m_rd}, cur.wr ? 2 : 1);
                end
            end
            prev_req = m_rd || m_wr;
            oh = cur_v ? CHN'(1) << cur.ch : '0;
            if (m_ack != '0) begin
                if (!cur_v) fail("ack_no_txn");
                chk("ch_ack", 32'(m_ack), 32'(oh));
                chk("ch_rdy_at_ack", 32'(m_rdy), cur.coinc ? 32'(oh) : 0);
                ack_cnt++;
                if (auto_drop)
                    for (int k = 0; k < CHN; k++)
                        if (m_ack[k]) begin ch_rd[k] = 1'b0; ch_wr[k] = 1'b0; end
            end
            if (m_rdy != '0) begin
                if (!cur_v) fail("rdy_no_txn");
                else if (cur.abort) fail("rdy_after_abort");
                chk("ch_rdy", 32'(m_rdy), 32'(oh));
                done_cnt++;
                cur_v = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int k, n, base;
        bit seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", m_busy, 0);
        chk("rst_rd", {m_rd, m_wr}, 0);
        chk("rst_dsn", m_dsn, 3);
        chk("rst_err", m_err, 0);
        chk("rst_addr", m_addr, 0);
        rst = 1'b0;

        // single read with hand-driven controller, cycle 0 = request
        cyc();
        set_addr(2, 22'h12345);
        expect_txn(2, 22'h12345, 16'h3333, 2'b00, 0, 0, 0);
        ch_rd[2] = 1'b1;
        cyc();
        @(negedge clk);
        chk("c1_rd", m_rd, 1);
        chk("c1_busy", m_busy, 1);
        cyc();
        cyc(); sdr_ack = 1'b1;
        @(negedge clk);
        chk("c3_ack", m_ack, 4'b0100);
        cyc(); sdr_ack = 1'b0;
        @(negedge clk);
        chk("c4_rd", m_rd, 0);
        chk("c4_busy", m_busy, 1);
        cyc();
        cyc(); sdr_dst = 1'b1;
        @(negedge clk);
        chk("c6_dst", m_dst, 4'b0100);
        cyc(); sdr_dst = 1'b0; sdr_dok = 1'b1;
        @(negedge clk);
        chk("c7_dok", m_dok, 4'b0100);
        cyc(); sdr_dok = 1'b0; sdr_rdy = 1'b1;
        @(negedge clk);
        chk("c8_rdy", m_rdy, 4'b0100);
        cyc(); sdr_rdy = 1'b0;
        @(negedge clk);
        chk("c9_busy", m_busy, 0);

        // round-robin: 0,1,3 then 0 again
        pulse_rst();
        base = done_cnt;
        ctl_en = 1'b1; ack_dly = 1; rdy_dly = 2; coinc = 1'b0;
        set_addr(0, 22'h100); set_addr(1, 22'h200); set_addr(3, 22'h300);
        expect_txn(0, 22'h100, 16'h1111, 2'b00, 0, 0, 0);
        expect_txn(1, 22'h200, 16'h2222, 2'b00, 0, 0, 0);
        expect_txn(3, 22'h300, 16'h4444, 2'b00, 0, 0, 0);
        expect_txn(0, 22'h111, 16'h1111, 2'b00, 0, 0, 0);
        ch_rd = 4'b1011;
        k = 0;
        while (ch_rd[0] && k < 50) begin @(negedge clk); #2; k++; end
        chk("rr_ch0_acked", ch_rd[0], 0);
        set_addr(0, 22'h111);
        ch_rd[0] = 1'b1;
        wait_done(base + 4, 200, "rr_done");
        settle();

        // write with ack and rdy coincident, then rd+wr counts as write
        base = done_cnt;
        ctl_en = 1'b1; coinc = 1'b1; ack_dly = 2;
        set_addr(1, 22'h2A);
        ch_din[16 +: 16] = 16'hBEEF;
        ch_dsn[2 +: 2] = 2'b01;
        expect_txn(1, 22'h2A, 16'hBEEF, 2'b01, 1, 1, 0);
        ch_wr[1] = 1'b1;
        wait_done(base + 1, 50, "wr_done");
        @(negedge clk);
        chk("wr_idle", m_busy, 0);
        coinc = 1'b0; rdy_dly = 1;
        set_addr(1, 22'h3C);
        ch_din[16 +: 16] = 16'h1234;
        ch_dsn[2 +: 2] = 2'b10;
        expect_txn(1, 22'h3C, 16'h1234, 2'b10, 1, 0, 0);
        ch_rd[1] = 1'b1; ch_wr[1] = 1'b1;
        wait_done(base + 2, 50, "rdwr_done");
        settle();

        // fixed priority on the second instance
        pulse_rst();
        sel_b = 1'b1;
        base = done_cnt;
        auto_drop = 1'b0;
        ctl_en = 1'b1; ack_dly = 0; rdy_dly = 1; coinc = 1'b0;
        set_addr(0, 22'h400); set_addr(3, 22'h700);
        expect_txn(0, 22'h400, 16'h1111, 2'b00, 0, 0, 0);
        expect_txn(0, 22'h400, 16'h1111, 2'b00, 0, 0, 0);
        expect_txn(0, 22'h400, 16'h1111, 2'b00, 0, 0, 0);
        expect_txn(3, 22'h700, 16'h4444, 2'b00, 0, 0, 0);
        ch_rd = 4'b1001;
        wait_done(base + 3, 100, "fp_ch0_done");
        ch_rd[0] = 1'b0;
        auto_drop = 1'b1;
        wait_done(base + 4, 50, "fp_ch3_done");
        settle();
        pulse_rst();
        sel_b = 1'b0;

        // watchdog: no ack ever arrives
        set_addr(2, 22'h5555);
        expect_txn(2, 22'h5555, 16'h3333, 2'b00, 0, 0, 1);
        ch_rd[2] = 1'b1;
        k = 0;
        while (!m_rd && k < 5) begin @(negedge clk); #2; k++; end
        n = 0;
        while (m_rd && n < 40) begin @(negedge clk); #2; n++; end
        ch_rd[2] = 1'b0;
        chk("wd_len", 32'(n >= 15 && n <= 16), 1);
        chk("wd_err", m_err, 1);
        chk("wd_busy", m_busy, 0);
        cyc(); sdr_rdy = 1'b1;
        @(negedge clk);
        chk("wd_no_rdy", m_rdy, 0);
        cyc(); sdr_rdy = 1'b0;
        base = done_cnt;
        ctl_en = 1'b1; ack_dly = 1; rdy_dly = 2;
        set_addr(1, 22'h666);
        expect_txn(1, 22'h666, 16'h2222, 2'b00, 0, 0, 0);
        ch_rd[1] = 1'b1;
        wait_done(base + 1, 50, "wd_after");
        chk("wd_err_sticky", m_err, 1);

        // hold blocks grants; reset in WAIT is immediate
        rdy_dly = 8;
        hold = 1'b1;
        set_addr(0, 22'h77);
        expect_txn(0, 22'h77, 16'h1111, 2'b00, 0, 0, 0);
        ch_rd[0] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (m_rd || m_busy) seen = 1'b1;
        end
        chk("hold_block", seen, 0);
        #2 hold = 1'b0;
        @(negedge clk);
        chk("hold_grant", m_rd, 1);
        n = ack_cnt;
        k = 0;
        while (ack_cnt == n && k < 10) begin @(negedge clk); #2; k++; end
        @(negedge clk);
        @(negedge clk);
        chk("wait_busy", m_busy, 1);
        chk("wait_rd", m_rd, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_rd", {m_rd, m_wr}, 0);
        chk("arst_addr", m_addr, 0);
        chk("arst_din", m_din, 0);
        chk("arst_dsn", m_dsn, 3);
        chk("arst_busy", m_busy, 0);
        chk("arst_err", m_err, 0);
        @(negedge clk);
        rst = 1'b0;
        ctl_en = 1'b0;
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
